im_fetch_ctrl: RTL and testbench

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

---
 rtl/im_fetch_ctrl_pkg.sv | 13 +
 rtl/im_seed_regfile.sv | 48 ++++
 rtl/im_fetch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_im_fetch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_ctrl_pkg.sv
// Shared definitions for the item-memory fetch controller: FSM states and
// the seed index that selects the CiM seed rather than an IM seed set.
package im_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } fetch_state_e;

  localparam int unsigned CimSeedIdx = 0;

endpackage

// File: rtl/im_seed_regfile.sv
// Seed storage: one CiM seed plus NumImSets IM seeds behind a single write port.
// Index 0 addresses the CiM seed, index k addresses IM set k-1; larger indices are dropped.
module im_seed_regfile
  import im_fetch_ctrl_pkg::*;
#(
  parameter int NumImSets = 8,
  parameter int SeedWidth = 32,
  parameter int SelWidth  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_i,
  input  logic [SelWidth-1:0]            sel_i,
  input  logic [SeedWidth-1:0]           data_i,
  output logic [SeedWidth-1:0]           cim_seed_o,
  output logic [NumImSets*SeedWidth-1:0] im_seed_o
);

  logic [SeedWidth-1:0]                cim_seed_q, cim_seed_d;
  logic [NumImSets-1:0][SeedWidth-1:0] im_seed_q, im_seed_d;

  always_comb begin
    cim_seed_d = cim_seed_q;
    im_seed_d  = im_seed_q;
    if (wr_i && (sel_i == SelWidth'(CimSeedIdx))) begin
      cim_seed_d = data_i;
    end
    for (int k = 0; k < NumImSets; k++) begin
      if (wr_i && (sel_i == SelWidth'(k + 1))) begin
        im_seed_d[k] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cim_seed_q <= '0;
      im_seed_q  <= '0;
    end else begin
      cim_seed_q <= cim_seed_d;
      im_seed_q  <= im_seed_d;
    end
  end

  assign cim_seed_o = cim_seed_q;
  assign im_seed_o  = im_seed_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Item-memory fetch controller: accepts a two-port fetch request, reads the item memory
// for one cycle and holds the response until handshaken. Optional perf counters: IM_FETCH_CTRL_PERF_EN.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter  int HVDimension  = 512,
  parameter  int NumTotIm     = 1024,
  parameter  int NumPerImBank = 128,
  parameter  int ImAddrWidth  = 32,
  parameter  int SeedWidth    = 32,
  localparam int NumImSets    = NumTotIm / NumPerImBank,
  localparam int CfgSelWidth  = $clog2(NumImSets + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
`ifdef IM_FETCH_CTRL_PERF_EN
  input  logic                           perf_clr_i,
  output logic [31:0]                    perf_fetch_o,
  output logic [31:0]                    perf_stall_o,
`endif
  input  logic                           cfg_wr_i,
  input  logic [CfgSelWidth-1:0]         cfg_sel_i,
  input  logic [SeedWidth-1:0]           cfg_data_i,
  output logic                           cfg_ready_o,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_cim_i,
  input  logic [ImAddrWidth-1:0]         req_addr_a_i,
  input  logic [ImAddrWidth-1:0]         req_addr_b_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [HVDimension-1:0]         rsp_a_o,
  output logic [HVDimension-1:0]         rsp_b_o,
  output logic                           rsp_err_o,
  output logic                           busy_o,
  output logic                           port_a_cim_o,
  output logic [SeedWidth-1:0]           cim_seed_o,
  output logic [NumImSets*SeedWidth-1:0] im_seed_o,
  output logic [ImAddrWidth-1:0]         im_a_addr_o,
  output logic [ImAddrWidth-1:0]         im_b_addr_o,
  input  logic [HVDimension-1:0]         im_a_i,
  input  logic [HVDimension-1:0]         im_b_i
);

  localparam logic [ImAddrWidth-1:0] TotImLimit  = ImAddrWidth'(NumTotIm);
  localparam logic [ImAddrWidth-1:0] CimLimit    = ImAddrWidth'(HVDimension / 2);

  fetch_state_e           state_q, state_d;
  logic                   req_cim_q, req_cim_d;
  logic [ImAddrWidth-1:0] addr_a_q, addr_a_d;
  logic [ImAddrWidth-1:0] addr_b_q, addr_b_d;
  logic [HVDimension-1:0] rsp_a_q, rsp_a_d;
  logic [HVDimension-1:0] rsp_b_q, rsp_b_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   req_fire, rsp_fire, cfg_fire;
  logic                   err_a, err_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = FETCH;
      FETCH:   state_d = RESP;
      RESP:    if (rsp_fire) state_d = req_fire ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config wins over a request in IDLE; in RESP a new request rides on the response handshake.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cfg_ready_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready_o = !cfg_wr_i;
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      FETCH: ;
      RESP: begin
        req_ready_o = rsp_ready_i;
        rsp_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_fire = req_valid_i && req_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;
  assign cfg_fire = cfg_wr_i && cfg_ready_o;

  assign err_a = req_cim_q ? (addr_a_q >= CimLimit) : (addr_a_q >= TotImLimit);
  assign err_b = (addr_b_q >= TotImLimit);

  always_comb begin
    req_cim_d = req_cim_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    rsp_a_d   = rsp_a_q;
    rsp_b_d   = rsp_b_q;
    rsp_err_d = rsp_err_q;
    if (req_fire) begin
      req_cim_d = req_cim_i;
      addr_a_d  = req_addr_a_i;
      addr_b_d  = req_addr_b_i;
    end
    if (state_q == FETCH) begin
      rsp_a_d   = err_a ? '0 : im_a_i;
      rsp_b_d   = err_b ? '0 : im_b_i;
      rsp_err_d = err_a || err_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_cim_q <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      rsp_a_q   <= '0;
      rsp_b_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      req_cim_q <= req_cim_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign port_a_cim_o = req_cim_q;
  assign im_a_addr_o  = addr_a_q;
  assign im_b_addr_o  = addr_b_q;
  assign rsp_a_o      = rsp_a_q;
  assign rsp_b_o      = rsp_b_q;
  assign rsp_err_o    = rsp_err_q;

  im_seed_regfile #(
    .NumImSets (NumImSets),
    .SeedWidth (SeedWidth),
    .SelWidth  (CfgSelWidth)
  ) u_seed_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_i       (cfg_fire),
    .sel_i      (cfg_sel_i),
    .data_i     (cfg_data_i),
    .cim_seed_o (cim_seed_o),
    .im_seed_o  (im_seed_o)
  );

`ifdef IM_FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counters; a clear in the same cycle beats any increment.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (perf_clr_i) begin
      perf_fetch_d = '0;
      perf_stall_d = '0;
    end else begin
      if (rsp_fire && (perf_fetch_q != '1)) perf_fetch_d = perf_fetch_q + 32'd1;
      if (rsp_valid_o && !rsp_ready_i && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_im_fetch_ctrl;

  localparam int HVD   = 512;
  localparam int NTI   = 1024;
  localparam int AW    = 32;
  localparam int SW    = 32;
  localparam int NSETS = 8;
  localparam int SELW  = 4;

  typedef logic [HVD-1:0] hv_t;
  typedef struct {
    hv_t  a;
    hv_t  b;
    logic err;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              cfg_wr;
  logic [SELW-1:0]   cfg_sel;
  logic [SW-1:0]     cfg_data;
  logic              cfg_ready_o;
  logic              req_valid;
  logic              req_ready_o;
  logic              req_cim;
  logic [AW-1:0]     req_addr_a;
  logic [AW-1:0]     req_addr_b;
  logic              rsp_valid_o;
  logic              rsp_ready;
  hv_t               rsp_a_o;
  hv_t               rsp_b_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic              port_a_cim_o;
  logic [SW-1:0]     cim_seed_o;
  logic [NSETS*SW-1:0] im_seed_o;
  logic [AW-1:0]     im_a_addr_o;
  logic [AW-1:0]     im_b_addr_o;
  hv_t               im_a;
  hv_t               im_b;
`ifdef IM_FETCH_CTRL_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_fetch_o;
  logic [31:0]       perf_stall_o;
`endif

  int testsRun;
  int testsFailed;
  exp_t expQ[$];
  exp_t monExp;
  logic [NSETS*SW-1:0] imSeedModel;
  logic [SW-1:0]       cimSeedModel;

  im_fetch_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
`ifdef IM_FETCH_CTRL_PERF_EN
    .perf_clr_i   (perf_clr),
    .perf_fetch_o (perf_fetch_o),
    .perf_stall_o (perf_stall_o),
`endif
    .cfg_wr_i     (cfg_wr),
    .cfg_sel_i    (cfg_sel),
    .cfg_data_i   (cfg_data),
    .cfg_ready_o  (cfg_ready_o),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_cim_i    (req_cim),
    .req_addr_a_i (req_addr_a),
    .req_addr_b_i (req_addr_b),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_a_o      (rsp_a_o),
    .rsp_b_o      (rsp_b_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .port_a_cim_o (port_a_cim_o),
    .cim_seed_o   (cim_seed_o),
    .im_seed_o    (im_seed_o),
    .im_a_addr_o  (im_a_addr_o),
    .im_b_addr_o  (im_b_addr_o),
    .im_a_i       (im_a),
    .im_b_i       (im_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden item-memory contents; CiM and IM differ so a wrong port-A select shows up.
  function automatic hv_t imHv(input logic [AW-1:0] addr);
    hv_t v;
    for (int i = 0; i < HVD / 32; i++)
      v[i*32 +: 32] = (addr * 32'h9E3779B1) ^ (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    return v;
  endfunction

  function automatic hv_t cimHv(input logic [AW-1:0] addr);
    hv_t v;
    for (int i = 0; i < HVD / 32; i++)
      v[i*32 +: 32] = (addr * 32'h85EBCA6B) ^ (32'(i) * 32'h00F000F1) ^ 32'hC3C3C3C3;
    return v;
  endfunction

  always_comb begin
    im_a = port_a_cim_o ? cimHv(im_a_addr_o) : imHv(im_a_addr_o);
    im_b = imHv(im_b_addr_o);
  end

  function automatic exp_t expFor(input logic cim, input logic [AW-1:0] a, input logic [AW-1:0] b);
    exp_t e;
    logic errA, errB;
    errA  = cim ? (a >= AW'(HVD / 2)) : (a >= AW'(NTI));
    errB  = (b >= AW'(NTI));
    e.a   = errA ? '0 : (cim ? cimHv(a) : imHv(a));
    e.b   = errB ? '0 : imHv(b);
    e.err = errA || errB;
    return e;
  endfunction

  task automatic checkOutput(input string name, input hv_t actual, input hv_t expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Response monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready) begin
      checkOutput("rsp_has_pending_req", hv_t'(expQ.size() != 0), hv_t'(1));
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("rsp_a", rsp_a_o, monExp.a);
        checkOutput("rsp_b", rsp_b_o, monExp.b);
        checkOutput("rsp_err", hv_t'(rsp_err_o), hv_t'(monExp.err));
      end
    end
  end

  task automatic applyStimulus(input logic cim, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               output time acceptT);
    logic accepted;
    accepted   = 1'b0;
    acceptT    = 0;
    req_valid  = 1'b1;
    req_cim    = cim;
    req_addr_a = a;
    req_addr_b = b;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        accepted = 1'b1;
        expQ.push_back(expFor(cim, a, b));
      end
      @(posedge clk);
      #1;
    end
    acceptT   = $time;
    req_valid = 1'b0;
    checkOutput("req_accepted", hv_t'(accepted), hv_t'(1));
  endtask

  task automatic cfgWrite(input logic [SELW-1:0] sel, input logic [SW-1:0] data);
    cfg_wr   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    if (sel == 0) cimSeedModel = data;
    else if (sel <= NSETS) imSeedModel[(sel-1)*SW +: SW] = data;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time t0, t1, t2, t3;
    testsRun     = 0;
    testsFailed  = 0;
    rst_n        = 1'b0;
    cfg_wr       = 1'b0;
    cfg_sel      = '0;
    cfg_data     = '0;
    req_valid    = 1'b0;
    req_cim      = 1'b0;
    req_addr_a   = '0;
    req_addr_b   = '0;
    rsp_ready    = 1'b1;
    imSeedModel  = '0;
    cimSeedModel = '0;
`ifdef IM_FETCH_CTRL_PERF_EN
    perf_clr     = 1'b0;
`endif

    // Reset state
    #22;
    checkOutput("rst_rsp_valid", hv_t'(rsp_valid_o), '0);
    checkOutput("rst_busy", hv_t'(busy_o), '0);
    checkOutput("rst_rsp_a", rsp_a_o, '0);
    checkOutput("rst_rsp_err", hv_t'(rsp_err_o), '0);
    checkOutput("rst_port_a_cim", hv_t'(port_a_cim_o), '0);
    checkOutput("rst_im_a_addr", hv_t'(im_a_addr_o), '0);
    checkOutput("rst_im_seed", hv_t'(im_seed_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_req_ready", hv_t'(req_ready_o), hv_t'(1));
    checkOutput("rel_cfg_ready", hv_t'(cfg_ready_o), hv_t'(1));
    @(posedge clk);
    #1;

    // Seed writes, including the last IM set and a discarded out-of-range index
    cfgWrite(4'd1, 32'hDEADBEEF);
    checkOutput("seed1", hv_t'(im_seed_o[31:0]), hv_t'(32'hDEADBEEF));
    checkOutput("cim_seed_untouched", hv_t'(cim_seed_o), '0);
    cfgWrite(4'd0, 32'h12345678);
    checkOutput("cim_seed", hv_t'(cim_seed_o), hv_t'(32'h12345678));
    cfgWrite(4'd8, 32'h88888888);
    checkOutput("seed8", hv_t'(im_seed_o), hv_t'(imSeedModel));
    cfgWrite(4'd9, 32'hFFFFFFFF);
    checkOutput("seed9_discard_im", hv_t'(im_seed_o), hv_t'(imSeedModel));
    checkOutput("seed9_discard_cim", hv_t'(cim_seed_o), hv_t'(cimSeedModel));

    // Basic request and its latency
    applyStimulus(1'b0, 32'd5, 32'd9, t0);
    checkOutput("fetch_rsp_valid", hv_t'(rsp_valid_o), '0);
    checkOutput("fetch_addr_a", hv_t'(im_a_addr_o), hv_t'(5));
    checkOutput("fetch_addr_b", hv_t'(im_b_addr_o), hv_t'(9));
    @(posedge clk);
    #1;
    checkOutput("resp_rsp_valid", hv_t'(rsp_valid_o), hv_t'(1));
    @(posedge clk);
    #1;
    checkOutput("after_hs_valid", hv_t'(rsp_valid_o), '0);
    checkOutput("after_hs_busy", hv_t'(busy_o), '0);
    checkOutput("addr_hold", hv_t'(im_a_addr_o), hv_t'(5));

    // Back-to-back boundary requests: one accept every two cycles
    applyStimulus(1'b1, 32'd256, 32'd17, t0);
    applyStimulus(1'b0, 32'd1023, 32'd1024, t1);
    applyStimulus(1'b1, 32'd255, 32'd0, t2);
    applyStimulus(1'b0, 32'd1024, 32'd1023, t3);
    checkOutput("b2b_gap1", hv_t'(t1 - t0), hv_t'(20));
    checkOutput("b2b_gap2", hv_t'(t2 - t1), hv_t'(20));
    checkOutput("b2b_gap3", hv_t'(t3 - t2), hv_t'(20));
    repeat (3) @(posedge clk);
    #1;

    // Stall with rsp_ready low; a config write during RESP must be ignored
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'd3, 32'd7, t0);
    @(posedge clk);
    #1;
    checkOutput("stall_valid", hv_t'(rsp_valid_o), hv_t'(1));
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        cfg_wr   = 1'b1;
        cfg_sel  = 4'd2;
        cfg_data = 32'hCAFEF00D;
      end
      @(negedge clk);
      checkOutput("stall_rsp_a", rsp_a_o, cimHv(32'd3));
      checkOutput("stall_rsp_b", rsp_b_o, imHv(32'd7));
      checkOutput("stall_req_ready", hv_t'(req_ready_o), '0);
      checkOutput("stall_cfg_ready", hv_t'(cfg_ready_o), '0);
      @(posedge clk);
      #1;
      cfg_wr = 1'b0;
    end
    checkOutput("stall_seed_ignored", hv_t'(im_seed_o), hv_t'(imSeedModel));
`ifdef IM_FETCH_CTRL_PERF_EN
    checkOutput("perf_stall", hv_t'(perf_stall_o), hv_t'(4));
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_done_busy", hv_t'(busy_o), '0);

    // Config and request together in IDLE: config first, request next cycle
    cfg_wr     = 1'b1;
    cfg_sel    = 4'd3;
    cfg_data   = 32'h0BADF00D;
    req_valid  = 1'b1;
    req_cim    = 1'b0;
    req_addr_a = 32'd100;
    req_addr_b = 32'd200;
    @(negedge clk);
    checkOutput("both_req_ready", hv_t'(req_ready_o), '0);
    checkOutput("both_cfg_ready", hv_t'(cfg_ready_o), hv_t'(1));
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    imSeedModel[2*SW +: SW] = 32'h0BADF00D;
    checkOutput("both_seed_first", hv_t'(im_seed_o), hv_t'(imSeedModel));
    checkOutput("both_req_waits", hv_t'(busy_o), '0);
    @(negedge clk);
    checkOutput("both_req_ready_next", hv_t'(req_ready_o), hv_t'(1));
    expQ.push_back(expFor(1'b0, 32'd100, 32'd200));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("both_req_accepted", hv_t'(busy_o), hv_t'(1));
    repeat (3) @(posedge clk);
    #1;

`ifdef IM_FETCH_CTRL_PERF_EN
    checkOutput("perf_fetch", hv_t'(perf_fetch_o), hv_t'(7));
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    checkOutput("perf_clr_fetch", hv_t'(perf_fetch_o), '0);
    checkOutput("perf_clr_stall", hv_t'(perf_stall_o), '0);
`endif

    // Reset while a response is pending drops it
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'd11, 32'd12, t0);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_valid", hv_t'(rsp_valid_o), hv_t'(1));
    #2;
    rst_n = 1'b0;
    expQ.delete();
    imSeedModel  = '0;
    cimSeedModel = '0;
    #1;
    checkOutput("mid_rst_valid", hv_t'(rsp_valid_o), '0);
    checkOutput("mid_rst_busy", hv_t'(busy_o), '0);
    checkOutput("mid_rst_seed", hv_t'(im_seed_o), hv_t'(imSeedModel));
    checkOutput("mid_rst_rsp_a", rsp_a_o, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_rsp", hv_t'(rsp_valid_o), '0);
    end

    checkOutput("queue_drained", hv_t'(expQ.size()), '0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
